// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
package lock_pkg;

  localparam int KEY_W  = 10;
  localparam int DIGITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROGRAM = 3'd3,
    ST_LOCKOUT = 3'd4
  } lock_state_t;

  function automatic logic is_onehot(input logic [KEY_W-1:0] key);
    return ($countones(key) == 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry-timeout, unlock and lockout phases.
module lock_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so a stale expiry stays asserted until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad door lock: sequential code entry, timed unlock, failure lockout and
// in-place code reprogramming while open.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [DIGITS*KEY_W-1:0] DEFAULT_CODE = {10'd1, 10'd512, 10'd8, 10'd2},
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int ENTRY_TIMEOUT  = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             key_valid,
  input  logic             prog,
  input  logic             relock,
  output logic             unlock,
  output logic             fail,
  output logic             lockout,
  output logic             key_err,
  output logic [2:0]       digit_cnt,
  output logic [1:0]       fail_cnt
);

  localparam int MAX_CYC_A = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > ENTRY_TIMEOUT) ? MAX_CYC_A : ENTRY_TIMEOUT;
  localparam int TW        = $clog2(MAX_CYC) + 1;
  localparam int DW        = $clog2(DIGITS);

  // Loaded with N-1 so the phase lasts exactly N cycles after its entry edge.
  localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_DIG = 3'(DIGITS - 1);
  localparam logic [1:0]    LAST_FAIL = 2'(MAX_FAILS - 1);

  lock_state_t state_q, state_d;
  logic [DIGITS*KEY_W-1:0] code_q, code_d;
  logic [KEY_W-1:0] shadow_q [DIGITS-1];
  logic [KEY_W-1:0] shadow_d [DIGITS-1];
  logic        mismatch_q, mismatch_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]  fail_cnt_q, fail_cnt_d;
  logic        unlock_q, unlock_d;
  logic        fail_q, fail_d;
  logic        lockout_q, lockout_d;
  logic        key_err_q, key_err_d;

  logic [KEY_W-1:0]        code_digit [DIGITS];
  logic [DIGITS*KEY_W-1:0] new_code;
  logic [DW-1:0]           didx;
  logic                    key_ok;
  logic                    last_dig;
  logic                    miss;
  logic                    tmr_load;
  logic [TW-1:0]           tmr_val;
  logic                    tmr_expired;

  // Digit 0 lives in the most significant slice of the code register.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign code_digit[gi] = code_q[(DIGITS-1-gi)*KEY_W +: KEY_W];
    if (gi == DIGITS - 1) begin : g_last
      assign new_code[(DIGITS-1-gi)*KEY_W +: KEY_W] = key;
    end else begin : g_rest
      assign new_code[(DIGITS-1-gi)*KEY_W +: KEY_W] = shadow_q[gi];
    end
  end

  assign didx     = digit_cnt_q[DW-1:0];
  assign key_ok   = is_onehot(key);
  assign last_dig = (digit_cnt_q == LAST_DIG);
  assign miss     = mismatch_q | (key != code_digit[didx]);

  lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    shadow_d    = shadow_q;
    mismatch_d  = mismatch_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_d      = 1'b0;
    key_err_d   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = T_ENTRY;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid) begin
          tmr_load = 1'b1;
          if (!key_ok) begin
            key_err_d = 1'b1;
          end else if (last_dig) begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            if (!miss) begin
              state_d    = ST_OPEN;
              fail_cnt_d = '0;
              tmr_val    = T_UNLOCK;
            end else begin
              fail_d     = 1'b1;
              fail_cnt_d = fail_cnt_q + 2'd1;
              if (fail_cnt_q == LAST_FAIL) begin
                state_d = ST_LOCKOUT;
                tmr_val = T_LOCK;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            digit_cnt_d = digit_cnt_q + 3'd1;
            mismatch_d  = miss;
            state_d     = ST_ENTRY;
          end
        end else if (state_q == ST_ENTRY && tmr_expired) begin
          state_d     = ST_IDLE;
          digit_cnt_d = '0;
          mismatch_d  = 1'b0;
        end
      end

      ST_OPEN: begin
        if (prog) begin
          state_d     = ST_PROGRAM;
          digit_cnt_d = '0;
          tmr_load    = 1'b1;
        end else if (relock || tmr_expired) begin
          state_d = ST_IDLE;
        end
      end

      ST_PROGRAM: begin
        if (key_valid) begin
          tmr_load = 1'b1;
          if (!key_ok) begin
            key_err_d = 1'b1;
          end else if (last_dig) begin
            code_d      = new_code;
            digit_cnt_d = '0;
            state_d     = ST_IDLE;
          end else begin
            shadow_d[didx] = key;
            digit_cnt_d    = digit_cnt_q + 3'd1;
          end
        end else if (tmr_expired) begin
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    unlock_d  = (state_d == ST_OPEN);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '{default: '0};
      mismatch_q  <= 1'b0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      lockout_q   <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      mismatch_q  <= mismatch_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      unlock_q    <= unlock_d;
      fail_q      <= fail_d;
      lockout_q   <= lockout_d;
      key_err_q   <= key_err_d;
    end
  end

  assign unlock    = unlock_q;
  assign fail      = fail_q;
  assign lockout   = lockout_q;
  assign key_err   = key_err_q;
  assign digit_cnt = digit_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequential controller for the keypad door lock. It accepts one-hot keypad digits one per strobe and compares the four-digit sequence against a stored code. It drives a timed unlock, counts failed attempts and enforces a lockout period. While open, it lets the code be reprogrammed. It replaces static parallel comparison of four digit inputs with a clocked entry sequence.

## Interface
- KEY_W, 10, keypad width; one-hot digit, bit i = digit i
- DIGITS, 4, code length in digits
- DEFAULT_CODE, {10'd1,10'd512,10'd8,10'd2}, reset code; first digit in MSB slice
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout
- UNLOCK_CYCLES, 500, cycles unlock stays high
- LOCKOUT_CYCLES, 1000, lockout duration in cycles
- ENTRY_TIMEOUT, 2000, idle cycles mid-entry before the partial entry is discarded
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key  in  KEY_W  keypad digit, sampled when key_valid is high
- key_valid  in  1  one-cycle digit strobe
- prog  in  1  request reprogramming; honoured only in OPEN
- relock  in  1  close early; honoured only in OPEN
- unlock  out  1  level, high in OPEN
- fail  out  1  one-cycle pulse per wrong complete code
- lockout  out  1  level, high in LOCKOUT
- key_err  out  1  one-cycle pulse on a non-one-hot key
- digit_cnt  out  3  digits accepted in the current entry
- fail_cnt  out  2  consecutive failures so far

## Operation
- States: IDLE, ENTRY, OPEN, PROGRAM, LOCKOUT. All outputs and fail_cnt reset to 0. The state resets to IDLE and the code register resets to DEFAULT_CODE.
- Valid key means exactly one bit of key is set. A zero or multi-hot key with key_valid asserted pulses key_err and is not counted. key_err fires in IDLE, ENTRY and PROGRAM.
- IDLE/ENTRY: each valid key is compared with code slice digit_cnt. A sticky mismatch flag ORs in each miss, and digit_cnt increments.
- When the DIGITS-th digit is accepted, digit_cnt returns to 0 and the mismatch flag clears.
  - Match: go to OPEN and clear fail_cnt.
  - Mismatch: pulse fail and increment fail_cnt. If fail_cnt reaches MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
- ENTRY timeout: after ENTRY_TIMEOUT cycles with no key_valid, go to IDLE, clear digit_cnt and the mismatch flag, and leave fail_cnt unchanged. This is not a failure.
- OPEN: the unlock timer expires or relock is asserted, then go to IDLE. prog goes to PROGRAM; prog wins over relock and key_valid in the same cycle. Keys are ignored in OPEN.
- PROGRAM: valid keys are written into a shadow register, MSB slice first. After DIGITS keys, the shadow register is copied to the code register atomically and the state goes to IDLE. An ENTRY_TIMEOUT in PROGRAM aborts to IDLE and keeps the old code.
- LOCKOUT: all keys, prog and relock are ignored, and key_err does not fire. On timer expiry, go to IDLE and clear fail_cnt.
- Asynchronous reset mid-operation returns everything to the reset values above, including the code register, and aborts all timers.

## Timing
- All outputs are registered.
- The key_valid of the last digit at edge N gives unlock or fail at edge N+1, so unlock is high from cycle N+1.
- unlock stays high for exactly UNLOCK_CYCLES cycles, unless relock or prog ends it early. relock at edge M drops unlock at edge M+1.
- lockout rises in the same cycle as the final fail pulse and stays high for LOCKOUT_CYCLES cycles.
- digit_cnt updates on the edge following each accepted key_valid.
- key_valid held high for k cycles counts as k digits; debouncing is upstream.
- The timer is a single down-counter reloaded on each state entry. Its width is $clog2 of the largest cycle parameter plus 1.

## Structure
- Shared package lock_pkg holds:
  - the state enum (lock_state_t);
  - KEY_W and DIGITS;
  - function is_onehot(key).
- One sub-module, lock_timer: a loadable down-counter with load, value and expired signals. It serves the entry timeout, unlock and lockout timers.
- The FSM, the comparators and the code/shadow registers stay in lock_ctrl.

## Test plan
- Keys 1, 512, 8, 2 after reset -> unlock high 1 cycle after the 4th key, for 500 cycles; fail_cnt = 0.
- Keys 256, 256, 1, 8 -> fail pulse, fail_cnt = 1, state IDLE, unlock stays 0.
- Three wrong codes in a row -> third fail pulse together with lockout = 1 for 1000 cycles. A correct code entered during lockout is ignored. After lockout, fail_cnt = 0.
- Key 36 (multi-hot) mid-entry -> key_err pulse, digit_cnt unchanged. Completing with the valid digits then unlocks.
- In OPEN: prog, then keys 256, 2, 1, 64 -> old code fails and the new code unlocks. Reset -> DEFAULT_CODE is restored.
- Two digits, then 2000 idle cycles -> digit_cnt = 0, no fail pulse. Reset asserted in OPEN -> unlock drops asynchronously.
